// File: rtl/fp_pkg.sv
// Shared single-precision constants and the divider FSM state encoding.
package fp_pkg;

  localparam int          FP_EXP_W   = 8;
  localparam int          FP_MAN_W   = 23;
  localparam logic [7:0]  FP_BIAS    = 8'd127;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  // Quotient bits produced by the divider: 25 significant + 1 guard.
  localparam int          FP_ITERS   = 26;
  localparam logic [4:0]  ITER_LAST  = 5'(FP_ITERS - 1);

  // Divider FSM states.
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_CALC = 2'd1;
  localparam logic [1:0]  ST_NORM = 2'd2;
  localparam logic [1:0]  ST_DONE = 2'd3;

endpackage

// File: rtl/fp_div_norm.sv
// Combinational normalise/round/special-case stage of the sequential divider.
// Optional feature macro: FP_DIV_ROUND_EN (round-to-nearest-even); when it is
// undefined the quotient is truncated.
module fp_div_norm
  import fp_pkg::*;
(
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  input  logic [FP_ITERS-1:0] quo_i,
  input  logic                rem_nz_i,
  output logic [31:0]         result_o,
  output logic                div_by_zero_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  logic                a_zero;
  logic                b_zero;
  logic                sign;
  logic                norm_shift;
  logic [24:0]         m25;       // 24-bit mantissa (hidden bit first) + guard
  logic signed [9:0]   e_raw;
  logic signed [9:0]   e_adj;
  logic signed [9:0]   e_fin;
  logic [FP_MAN_W-1:0] frac;
  logic                unused_bits;
`ifdef FP_DIV_ROUND_EN
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [24:0]         mant_rnd;
`endif

  // Normalise the quotient, apply rounding and pick the final result/flags.
  always_comb begin
    a_zero     = (a_i[30:23] == '0);
    b_zero     = (b_i[30:23] == '0);
    sign       = a_i[31] ^ b_i[31];
    e_raw      = $signed({2'b00, a_i[30:23]}) - $signed({2'b00, b_i[30:23]})
               + $signed({2'b00, FP_BIAS});
    // Mantissa ratio lies in (0.5, 2): at most one left shift normalises it.
    norm_shift = ~quo_i[FP_ITERS-1];
    m25        = norm_shift ? quo_i[24:0] : quo_i[25:1];
    e_adj      = e_raw - (norm_shift ? 10'sd1 : 10'sd0);
`ifdef FP_DIV_ROUND_EN
    guard    = m25[0];
    // A bit dropped by the unshifted case also counts towards sticky.
    sticky   = rem_nz_i | (quo_i[FP_ITERS-1] & quo_i[0]);
    round_up = guard & (sticky | m25[1]);
    mant_rnd = {1'b0, m25[24:1]} + 25'(round_up);
    if (mant_rnd[24]) begin
      frac  = '0;
      e_fin = e_adj + 10'sd1;
    end else begin
      frac  = mant_rnd[22:0];
      e_fin = e_adj;
    end
    unused_bits = mant_rnd[23];
`else
    frac        = m25[23:1];
    e_fin       = e_adj;
    unused_bits = ^{rem_nz_i, m25[24], m25[0]};
`endif

    result_o      = FP_ZERO;
    div_by_zero_o = 1'b0;
    overflow_o    = 1'b0;
    underflow_o   = 1'b0;
    if (a_zero) begin
      result_o = FP_ZERO;
    end else if (b_zero) begin
      result_o      = {sign, FP_POS_INF[30:0]};
      div_by_zero_o = 1'b1;
    end else if (e_adj <= 10'sd0) begin
      underflow_o = 1'b1;
    end else if (e_fin >= 10'sd255) begin
      result_o   = {sign, FP_POS_INF[30:0]};
      overflow_o = 1'b1;
    end else begin
      result_o = {sign, e_fin[FP_EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider (restoring radix-2, one
// quotient bit per clock, fixed 28-cycle start-to-done latency).
// Optional feature macro: FP_DIV_ROUND_EN (handled in fp_div_norm).
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  logic [1:0]          state_q, state_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [24:0]         rem_q, rem_d;
  logic [23:0]         div_q, div_d;
  logic [FP_ITERS-1:0] quo_q, quo_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [31:0]         result_q, result_d;
  logic                dbz_q, dbz_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic                rem_ge;
  logic [24:0]         rem_sub;
  logic [31:0]         norm_result;
  logic                norm_dbz;
  logic                norm_ovf;
  logic                norm_unf;

  fp_div_norm u_norm (
    .a_i           (a_q),
    .b_i           (b_q),
    .quo_i         (quo_q),
    .rem_nz_i      (|rem_q),
    .result_o      (norm_result),
    .div_by_zero_o (norm_dbz),
    .overflow_o    (norm_ovf),
    .underflow_o   (norm_unf)
  );

  // FSM sequencing plus one restoring-division step per CALC cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    rem_ge  = (rem_q >= {1'b0, div_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          rem_d   = {2'b01, a[FP_MAN_W-1:0]};
          div_d   = {1'b1, b[FP_MAN_W-1:0]};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // After a restoring step rem < div < 2^24, so the shift never overflows.
        rem_d = rem_sub << 1;
        quo_d = {quo_q[FP_ITERS-2:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        result_d = norm_result;
        dbz_d    = norm_dbz;
        ovf_d    = norm_ovf;
        unf_d    = norm_unf;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy        = (state_q == ST_CALC) || (state_q == ST_NORM);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed testbench for fp_div_seq.
module tb_fp_div_seq;

`ifdef FP_DIV_ROUND_EN
  localparam logic [31:0] EXP_THIRD = 32'h3EAA_AAAB;
`else
  localparam logic [31:0] EXP_THIRD = 32'h3EAA_AAAA;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;
  logic        overflow;
  logic        underflow;

  int tests = 0;
  int fails = 0;

  // Values captured by run_op at the done cycle.
  logic [31:0] r_res;
  logic [2:0]  r_flags;
  int          r_lat;
  logic        r_busy_bad;

  fp_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Issue one operation; cycle 1 is the period right after the start edge.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    r_lat = -1;
    r_busy_bad = 1'b0;
    r_res = '0;
    r_flags = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        r_lat = c;
        r_res = result;
        r_flags = {div_by_zero, overflow, underflow};
        if (busy) r_busy_bad = 1'b1;
        break;
      end
      if (!busy) r_busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    tests++;
    if (result !== 32'h0) begin
      fails++;
      $display("FAIL reset_result: got %h expected 00000000", result);
    end
    tests++;
    if ({div_by_zero, overflow, underflow} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 000", {div_by_zero, overflow, underflow});
    end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic;
    run_op(32'h40C0_0000, 32'h4000_0000);
    $display("[TB] 40c00000 / 40000000 -> %h flags %b lat %0d", r_res, r_flags, r_lat);
    tests++;
    if (r_lat !== 28) begin
      fails++;
      $display("FAIL basic_latency: got %0d expected 28", r_lat);
    end
    tests++;
    if (r_busy_bad !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy: busy wrong during cycles 1..28 got %b expected 0", r_busy_bad);
    end
    tests++;
    if (r_res !== 32'h4040_0000) begin
      fails++;
      $display("FAIL basic_result: got %h expected 40400000", r_res);
    end
    tests++;
    if (r_flags !== 3'b000) begin
      fails++;
      $display("FAIL basic_flags: got %b expected 000", r_flags);
    end
    @(negedge clk);
    tests++;
    if ({busy, done, (result == 32'h4040_0000)} !== 3'b001) begin
      fails++;
      $display("FAIL basic_after: busy/done/held got %b expected 001", {busy, done, (result == 32'h4040_0000)});
    end
  endtask

  task automatic test_round;
    run_op(32'h3F80_0000, 32'h4040_0000);
    $display("[TB] 3f800000 / 40400000 -> %h flags %b", r_res, r_flags);
    tests++;
    if (r_res !== EXP_THIRD) begin
      fails++;
      $display("FAIL third_result: got %h expected %h", r_res, EXP_THIRD);
    end
    tests++;
    if (r_flags !== 3'b000) begin
      fails++;
      $display("FAIL third_flags: got %b expected 000", r_flags);
    end
  endtask

  task automatic test_sign_zero;
    run_op(32'hC100_0000, 32'h3F00_0000);
    $display("[TB] c1000000 / 3f000000 -> %h flags %b", r_res, r_flags);
    tests++;
    if ({r_res, r_flags} !== {32'hC180_0000, 3'b000}) begin
      fails++;
      $display("FAIL neg_div: got %h/%b expected c1800000/000", r_res, r_flags);
    end
    run_op(32'h0000_0000, 32'h40A0_0000);
    $display("[TB] 00000000 / 40a00000 -> %h flags %b", r_res, r_flags);
    tests++;
    if ({r_res, r_flags} !== {32'h0000_0000, 3'b000}) begin
      fails++;
      $display("FAIL zero_dividend: got %h/%b expected 00000000/000", r_res, r_flags);
    end
    tests++;
    if (r_lat !== 28) begin
      fails++;
      $display("FAIL zero_latency: got %0d expected 28", r_lat);
    end
  endtask

  task automatic test_special;
    run_op(32'h40A0_0000, 32'h0000_0000);
    $display("[TB] 40a00000 / 00000000 -> %h flags %b", r_res, r_flags);
    tests++;
    if ({r_res, r_flags} !== {32'h7F80_0000, 3'b100}) begin
      fails++;
      $display("FAIL div_zero: got %h/%b expected 7f800000/100", r_res, r_flags);
    end
    run_op(32'h7F00_0000, 32'h0080_0000);
    $display("[TB] 7f000000 / 00800000 -> %h flags %b", r_res, r_flags);
    tests++;
    if ({r_res, r_flags} !== {32'h7F80_0000, 3'b010}) begin
      fails++;
      $display("FAIL overflow: got %h/%b expected 7f800000/010", r_res, r_flags);
    end
    run_op(32'h0080_0000, 32'h7F00_0000);
    $display("[TB] 00800000 / 7f000000 -> %h flags %b", r_res, r_flags);
    tests++;
    if ({r_res, r_flags} !== {32'h0000_0000, 3'b001}) begin
      fails++;
      $display("FAIL underflow: got %h/%b expected 00000000/001", r_res, r_flags);
    end
    tests++;
    if (r_lat !== 28) begin
      fails++;
      $display("FAIL underflow_latency: got %0d expected 28", r_lat);
    end
  endtask

  task automatic test_start_ignored;
    int          ndone;
    logic [31:0] got;
    ndone = 0;
    got = '0;
    @(negedge clk);
    a = 32'h40C0_0000;
    b = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        got = result;
      end
      if (c == 5 || c == 28) begin
        a = 32'h3F80_0000;
        b = 32'h4040_0000;
        start = 1'b1;
      end
      if (c == 6 || c == 29) start = 1'b0;
    end
    $display("[TB] start during busy/done: %0d done pulses, result %h", ndone, got);
    tests++;
    if (ndone !== 1) begin
      fails++;
      $display("FAIL ignore_count: got %0d done pulses expected 1", ndone);
    end
    tests++;
    if (got !== 32'h4040_0000) begin
      fails++;
      $display("FAIL ignore_result: got %h expected 40400000", got);
    end
  endtask

  task automatic test_back_to_back;
    run_op(32'hC100_0000, 32'h3F00_0000);
    run_op(32'h40C0_0000, 32'h4000_0000);
    $display("[TB] back-to-back second op -> %h lat %0d", r_res, r_lat);
    tests++;
    if ({r_res, r_lat} !== {32'h4040_0000, 32'd28}) begin
      fails++;
      $display("FAIL back_to_back: got %h lat %0d expected 40400000 lat 28", r_res, r_lat);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    run_op(32'h40C0_0000, 32'h4000_0000);
    @(negedge clk);
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset mid-CALC: busy %b done %b result %h", busy, done, result);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL midrst_busy_done: got %b expected 00", {busy, done});
    end
    tests++;
    if ({result, div_by_zero, overflow, underflow} !== 35'h0) begin
      fails++;
      $display("FAIL midrst_outputs: got %h/%b expected 00000000/000", result, {div_by_zero, overflow, underflow});
    end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL midrst_no_done: got %0d done pulses expected 0", ndone);
    end
    run_op(32'hC100_0000, 32'h3F00_0000);
    $display("[TB] after mid reset -> %h lat %0d", r_res, r_lat);
    tests++;
    if ({r_res, r_lat} !== {32'hC180_0000, 32'd28}) begin
      fails++;
      $display("FAIL midrst_recover: got %h lat %0d expected c1800000 lat 28", r_res, r_lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_round();
    test_sign_zero();
    test_special();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
